hub75_scan_seq: RTL

Next-generation scan sequencer for the HUB75 panel pipeline. It replaces the fixed scan and frame-swap glue with one parametrised controller. Per row it prefetches framebuffer data, then hands the row to the BCM modulator. Over the single-swap design it adds selectable row scan order, per-row display repeat, double or triple buffer management, enable/stop at frame boundary, and a frame counter.

---
 rtl/hub75_pkg.sv | 18 +
 rtl/hub75_fb_index.sv | 79 +++++++
 rtl/hub75_scan_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared constants for the HUB75 scan sequencer.
// Scan-mode codes and FSM state encodings.
package hub75_pkg;

   localparam logic [1:0] SCAN_LINEAR      = 2'd0;
   localparam logic [1:0] SCAN_INTERLEAVED = 2'd1;
   localparam logic [1:0] SCAN_REVERSE     = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_PAINT  = 3'd3,
      ST_REPEAT = 3'd4,
      ST_FEND   = 3'd5
   } state_t;

endpackage

// File: rtl/hub75_fb_index.sv
// Frame buffer index rotation: double buffer with pending flag,
// or triple buffer with a ready slot that drops stale frames.
module hub75_fb_index #(
   parameter int N_FB     = 2,
   parameter int LOG_N_FB = $clog2(N_FB)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_swap,
   input  logic                fend,
   output logic [LOG_N_FB-1:0] front_sel,
   output logic [LOG_N_FB-1:0] back_sel,
   output logic                frame_rdy
);

   generate
      if (N_FB == 2) begin : g_dbl
         logic pending;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pending   <= 1'b0;
               front_sel <= '0;
               back_sel  <= LOG_N_FB'(1);
            end else if (fend && pending) begin
               front_sel <= back_sel;
               back_sel  <= front_sel;
               pending   <= 1'b0;
            end else if (frame_swap) begin
               pending <= 1'b1;
            end
         end

         assign frame_rdy = ~pending;
      end else begin : g_tpl
         logic [LOG_N_FB-1:0] spare, ready;
         logic [LOG_N_FB-1:0] front_n, back_n, spare_n, ready_n;
         logic                ready_v, ready_v_n;

         // Frame end sees the pre-swap ready slot; a same-cycle swap lands after it.
         always_comb begin
            front_n   = front_sel;
            back_n    = back_sel;
            spare_n   = spare;
            ready_n   = ready;
            ready_v_n = ready_v;
            if (fend && ready_v) begin
               front_n   = ready;
               spare_n   = front_sel;
               ready_v_n = 1'b0;
            end
            if (frame_swap) begin
               ready_n   = back_sel;
               back_n    = ready_v_n ? ready : spare_n;
               ready_v_n = 1'b1;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               front_sel <= '0;
               back_sel  <= LOG_N_FB'(1);
               spare     <= LOG_N_FB'(2);
               ready     <= '0;
               ready_v   <= 1'b0;
            end else begin
               front_sel <= front_n;
               back_sel  <= back_n;
               spare     <= spare_n;
               ready     <= ready_n;
               ready_v   <= ready_v_n;
            end
         end

         assign frame_rdy = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/hub75_scan_seq.sv
// HUB75 row scan sequencer: prefetch, paint, repeat passes,
// frame-boundary enable and buffer rotation.
module hub75_scan_seq
   import hub75_pkg::*;
#(
   parameter int N_ROWS     = 32,
   parameter int N_FB       = 2,
   parameter int LOG_N_ROWS = $clog2(N_ROWS),
   parameter int LOG_N_FB   = $clog2(N_FB)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_enable,
   input  logic [1:0]            cfg_scan_mode,
   input  logic [3:0]            cfg_row_repeat,
   output logic [LOG_N_ROWS-1:0] fb_row_addr,
   output logic                  fb_row_load,
   input  logic                  fb_row_rdy,
   output logic                  fb_row_swap,
   output logic [LOG_N_ROWS-1:0] bcm_row,
   output logic                  bcm_go,
   input  logic                  bcm_rdy,
   input  logic                  frame_swap,
   output logic                  frame_rdy,
   output logic [LOG_N_FB-1:0]   fb_front_sel,
   output logic [LOG_N_FB-1:0]   fb_back_sel,
   output logic [15:0]           frame_cnt
);

   localparam logic [LOG_N_ROWS-1:0] LAST_ROW = LOG_N_ROWS'(N_ROWS - 1);

   state_t                state, state_n;
   logic [LOG_N_ROWS-1:0] idx;
   logic [1:0]            mode_q;
   logic [3:0]            rep_cfg;
   logic [3:0]            rep;
   logic                  last;
   logic                  fend_fire;
   logic                  relatch;
   logic                  rep_go;
   logic                  paint_ok;

   // Interleave is a rotate-left of the slot index: evens first, then odds.
   function automatic logic [LOG_N_ROWS-1:0] row_order(
      input logic [LOG_N_ROWS-1:0] i,
      input logic [1:0]            m
   );
      logic [LOG_N_ROWS-1:0] r;
      unique case (1'b1)
         (m == SCAN_INTERLEAVED):
            r = (i << 1) | LOG_N_ROWS'(i[LOG_N_ROWS-1]);
         (m == SCAN_REVERSE):
            r = ~i;
         default:
            r = i;
      endcase
      return r;
   endfunction

   assign last      = (idx == LAST_ROW);
   assign fend_fire = (state == ST_FEND) && bcm_rdy;
   assign relatch   = ((state == ST_IDLE) && cfg_enable) ||
                      (fend_fire && cfg_enable);
   assign rep_go    = ((state == ST_WAIT) || (state == ST_REPEAT)) &&
                      (rep != '0) && bcm_rdy;
   assign paint_ok  = (state == ST_WAIT) && (rep == '0) &&
                      fb_row_rdy && bcm_rdy;

   assign fb_row_addr = row_order(idx, mode_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE:   if (cfg_enable) state_n = ST_LOAD;
         ST_LOAD:   state_n = ST_WAIT;
         ST_WAIT:   if (paint_ok) state_n = ST_PAINT;
         ST_PAINT:  state_n = last ? ST_REPEAT : ST_LOAD;
         ST_REPEAT: if (rep == '0) state_n = ST_FEND;
         ST_FEND:
            if (bcm_rdy) state_n = cfg_enable ? ST_LOAD : ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      fb_row_load = (state == ST_LOAD);
      fb_row_swap = (state == ST_PAINT);
      bcm_go      = (state == ST_PAINT) || rep_go;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         mode_q    <= SCAN_LINEAR;
         rep_cfg   <= '0;
         rep       <= '0;
         bcm_row   <= '0;
         frame_cnt <= '0;
      end else begin
         if (relatch) begin
            mode_q  <= cfg_scan_mode;
            rep_cfg <= cfg_row_repeat;
            idx     <= '0;
         end
         if (paint_ok) bcm_row <= row_order(idx, mode_q);
         // idx moves on at paint so the next prefetch overlaps this row's passes.
         if (state == ST_PAINT) begin
            rep <= rep_cfg;
            if (!last) idx <= idx + LOG_N_ROWS'(1);
         end else if (rep_go) begin
            rep <= rep - 4'd1;
         end
         if (fend_fire) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   hub75_fb_index #(
      .N_FB     (N_FB),
      .LOG_N_FB (LOG_N_FB)
   ) u_fb_index (
      .clk        (clk),
      .rst        (rst),
      .frame_swap (frame_swap),
      .fend       (fend_fire),
      .front_sel  (fb_front_sel),
      .back_sel   (fb_back_sel),
      .frame_rdy  (frame_rdy)
   );

endmodule
